// File: rtl/complete_pkg.sv
// Shared constants for the TFT cursor painter:
// panel commands, RGB565 palette, grid geometry and sequencer states.
package complete_pkg;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   localparam logic [7:0] COLMOD_565 = 8'h55;
   localparam logic [7:0] MADCTL_DEF = 8'h00;

   localparam int GRID_X = 24;
   localparam int GRID_Y = 32;

   localparam logic [4:0] X_MAX = 5'd23;
   localparam logic [4:0] Y_MAX = 5'd31;
   localparam logic [4:0] X_CTR = 5'd12;
   localparam logic [4:0] Y_CTR = 5'd16;

   // Button bit positions, highest service priority first
   localparam int B_KEY   = 5;
   localparam int B_MODE  = 4;
   localparam int B_UP    = 3;
   localparam int B_DOWN  = 2;
   localparam int B_LEFT  = 1;
   localparam int B_RIGHT = 0;

   // Bytes before the pixel stream: 2A+4, 2B+4, 2C
   localparam logic [3:0] HDR_LEN = 4'd11;

   typedef enum logic [3:0] {
      S_WAIT_PWR,
      S_SWRESET,
      S_WAIT_RST,
      S_SLPOUT,
      S_WAIT_SLP,
      S_COLMOD,
      S_MADCTL,
      S_DISPON,
      S_CLEAR,
      S_IDLE,
      S_DRAW
   } state_t;

   function automatic logic [15:0] palette(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0: c = 16'h0000;
         3'd1: c = 16'hF800;
         3'd2: c = 16'h07E0;
         3'd3: c = 16'h001F;
         3'd4: c = 16'hFFE0;
         3'd5: c = 16'h07FF;
         3'd6: c = 16'hF81F;
         3'd7: c = 16'hFFFF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/complete_lcd_byte_writer.sv
// 8080-style write-only byte strobe for the TFT bus.
// A byte takes two cycles: wr low with data, then wr high with data held.
module lcd_byte_writer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       is_data,
   input  logic [7:0] data,
   output logic       busy,
   output logic       dcx,
   output logic       wr,
   output logic [7:0] D
);

   logic phase;

   // Launch a byte with wr low, release wr next cycle; bus holds when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0;
         wr    <= 1'b1;
         dcx   <= 1'b1;
         D     <= 8'h00;
      end else if (phase) begin
         phase <= 1'b0;
         wr    <= 1'b1;
      end else if (start) begin
         phase <= 1'b1;
         wr    <= 1'b0;
         dcx   <= is_data;
         D     <= data;
      end
   end

   assign busy = phase;

endmodule

// File: rtl/complete_top.sv
// Image generator top: panel init, full clear, then a button-driven
// block cursor that paints one cell per move in the current colour.
module complete_top
   import complete_pkg::*;
#(
   parameter int DELAY_CYCLES = 10000,
   parameter int CELL         = 10
) (
   input  logic       hwclk,
   input  logic       nrst,
   input  logic       left,
   input  logic       right,
   input  logic       up,
   input  logic       down,
   input  logic       mode_pb,
   input  logic       KeyEnc,
   output logic       dcx,
   output logic       wr,
   output logic [7:0] D
);

   localparam int W  = GRID_X * CELL;
   localparam int H  = GRID_Y * CELL;
   localparam int CW = 20;

   localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY_CYCLES - 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(2 * W * H - 1);
   localparam logic [CW-1:0] CELL_LAST = CW'(2 * CELL * CELL - 1);
   localparam logic [15:0]   X_END     = 16'(W - 1);
   localparam logic [15:0]   Y_END     = 16'(H - 1);

   state_t        state, state_n, nxt;
   logic [3:0]    idx;
   logic [CW-1:0] cnt;
   logic [4:0]    cx, cy;
   logic [2:0]    colour;
   logic [5:0]    raw, s1, s2, s3;
   logic [5:0]    press, pend, serve;
   logic          start, busy, send, waiting, last;
   logic          tx_data, win_data;
   logic [7:0]    tx_byte, win_byte;
   logic [15:0]   xs, xe, ys, ye, pix;
   logic [CW-1:0] pix_last;

   assign raw   = {KeyEnc, mode_pb, up, down, left, right};
   assign press = s2 & ~s3;

   // Window bounds and pixel colour for a clear or a cell draw
   always_comb begin
      xs       = 16'h0000;
      xe       = X_END;
      ys       = 16'h0000;
      ye       = Y_END;
      pix      = 16'h0000;
      pix_last = CLR_LAST;
      if (state != S_CLEAR) begin
         xs       = 16'(cx) * 16'(CELL);
         xe       = xs + 16'(CELL - 1);
         ys       = 16'(cy) * 16'(CELL);
         ye       = ys + 16'(CELL - 1);
         pix      = palette(colour);
         pix_last = CELL_LAST;
      end
   end

   // Byte at the current window-write position
   always_comb begin
      win_data = 1'b1;
      win_byte = 8'h00;
      unique case (idx)
         4'd0: begin
            win_byte = CMD_CASET;
            win_data = 1'b0;
         end
         4'd1: win_byte = xs[15:8];
         4'd2: win_byte = xs[7:0];
         4'd3: win_byte = xe[15:8];
         4'd4: win_byte = xe[7:0];
         4'd5: begin
            win_byte = CMD_PASET;
            win_data = 1'b0;
         end
         4'd6: win_byte = ys[15:8];
         4'd7: win_byte = ys[7:0];
         4'd8: win_byte = ye[15:8];
         4'd9: win_byte = ye[7:0];
         4'd10: begin
            win_byte = CMD_RAMWR;
            win_data = 1'b0;
         end
         default: win_byte = cnt[0] ? pix[7:0] : pix[15:8];
      endcase
   end

   // Sequencer next state, byte to send and pending-flag service
   always_comb begin
      state_n = state;
      nxt     = state;
      send    = 1'b0;
      waiting = 1'b0;
      last    = 1'b1;
      tx_byte = 8'h00;
      tx_data = 1'b0;
      serve   = '0;
      start   = 1'b0;
      unique case (state)
         S_WAIT_PWR: begin
            waiting = 1'b1;
            nxt     = S_SWRESET;
         end
         S_SWRESET: begin
            send    = 1'b1;
            tx_byte = CMD_SWRESET;
            nxt     = S_WAIT_RST;
         end
         S_WAIT_RST: begin
            waiting = 1'b1;
            nxt     = S_SLPOUT;
         end
         S_SLPOUT: begin
            send    = 1'b1;
            tx_byte = CMD_SLPOUT;
            nxt     = S_WAIT_SLP;
         end
         S_WAIT_SLP: begin
            waiting = 1'b1;
            nxt     = S_COLMOD;
         end
         S_COLMOD: begin
            send    = 1'b1;
            tx_data = idx[0];
            tx_byte = idx[0] ? COLMOD_565 : CMD_COLMOD;
            last    = idx[0];
            nxt     = S_MADCTL;
         end
         S_MADCTL: begin
            send    = 1'b1;
            tx_data = idx[0];
            tx_byte = idx[0] ? MADCTL_DEF : CMD_MADCTL;
            last    = idx[0];
            nxt     = S_DISPON;
         end
         S_DISPON: begin
            send    = 1'b1;
            tx_byte = CMD_DISPON;
            nxt     = S_CLEAR;
         end
         S_CLEAR, S_DRAW: begin
            send    = 1'b1;
            tx_byte = win_byte;
            tx_data = win_data;
            last    = (idx == HDR_LEN) && (cnt == pix_last);
            nxt     = (state == S_CLEAR) ? S_DRAW : S_IDLE;
         end
         S_IDLE: begin
            if (pend[B_KEY]) begin
               serve[B_KEY] = 1'b1;
               state_n      = S_CLEAR;
            end else if (pend[B_MODE]) begin
               serve[B_MODE] = 1'b1;
               state_n       = S_DRAW;
            end else if (pend[B_UP]) begin
               serve[B_UP] = 1'b1;
               state_n     = S_DRAW;
            end else if (pend[B_DOWN]) begin
               serve[B_DOWN] = 1'b1;
               state_n       = S_DRAW;
            end else if (pend[B_LEFT]) begin
               serve[B_LEFT] = 1'b1;
               state_n       = S_DRAW;
            end else if (pend[B_RIGHT]) begin
               serve[B_RIGHT] = 1'b1;
               state_n        = S_DRAW;
            end
         end
         default: state_n = S_WAIT_PWR;
      endcase
      start = send & ~busy;
      if (waiting && cnt == DLY_LAST) begin
         state_n = nxt;
      end
      if (start && last) begin
         state_n = nxt;
      end
   end

   // Sequencer state register
   always_ff @(posedge hwclk or negedge nrst) begin
      if (!nrst) begin
         state <= S_WAIT_PWR;
      end else begin
         state <= state_n;
      end
   end

   // Delay / pixel-byte counter and header index, cleared per state
   always_ff @(posedge hwclk or negedge nrst) begin
      if (!nrst) begin
         idx <= '0;
         cnt <= '0;
      end else if (state_n != state) begin
         idx <= '0;
         cnt <= '0;
      end else if (waiting) begin
         cnt <= cnt + CW'(1);
      end else if (start) begin
         if (idx == HDR_LEN) begin
            cnt <= cnt + CW'(1);
         end else begin
            idx <= idx + 4'd1;
         end
      end
   end

   // Two-flop synchroniser plus one stage for rising-edge detect
   always_ff @(posedge hwclk or negedge nrst) begin
      if (!nrst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Pending presses; a fresh press wins over a same-cycle service
   always_ff @(posedge hwclk or negedge nrst) begin
      if (!nrst) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~serve) | press;
      end
   end

   // Cursor position and paint colour, updated by the served button
   always_ff @(posedge hwclk or negedge nrst) begin
      if (!nrst) begin
         cx     <= X_CTR;
         cy     <= Y_CTR;
         colour <= 3'd7;
      end else begin
         unique case (1'b1)
            serve[B_KEY]: begin
               cx <= X_CTR;
               cy <= Y_CTR;
            end
            serve[B_MODE]: colour <= colour + 3'd1;
            serve[B_UP]: begin
               if (cy != 5'd0) cy <= cy - 5'd1;
            end
            serve[B_DOWN]: begin
               if (cy != Y_MAX) cy <= cy + 5'd1;
            end
            serve[B_LEFT]: begin
               if (cx != 5'd0) cx <= cx - 5'd1;
            end
            serve[B_RIGHT]: begin
               if (cx != X_MAX) cx <= cx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   lcd_byte_writer u_writer (
      .clk    (hwclk),
      .rst_n  (nrst),
      .start  (start),
      .is_data(tx_data),
      .data   (tx_byte),
      .busy   (busy),
      .dcx    (dcx),
      .wr     (wr),
      .D      (D)
   );

endmodule

// File: tb/tb_complete_top.sv
// Bench for complete_top: byte stream on the LCD bus is captured and
// scored against expected init, clear and cell-draw sequences.
module tb_complete_top;

   localparam int DLY  = 40;
   localparam int CELL = 2;
   localparam int W    = 24 * CELL;
   localparam int H    = 32 * CELL;

   logic       hwclk = 1'b0;
   logic       nrst  = 1'b0;
   logic [5:0] btn   = '0;
   logic       dcx, wr;
   logic [7:0] D;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   complete_top #(
      .DELAY_CYCLES(DLY),
      .CELL        (CELL)
   ) dut (
      .hwclk  (hwclk),
      .nrst   (nrst),
      .left   (btn[1]),
      .right  (btn[0]),
      .up     (btn[3]),
      .down   (btn[2]),
      .mode_pb(btn[4]),
      .KeyEnc (btn[5]),
      .dcx    (dcx),
      .wr     (wr),
      .D      (D)
   );

   always #5 hwclk = ~hwclk;

   // Each byte has exactly one wr-low cycle; grab it mid-cycle
   always @(negedge hwclk) begin
      if (nrst && wr === 1'b0) obs_q.push_back({dcx, D});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: run did not end, need finish");
      $fatal(1);
   end

   task automatic push(input logic dc, input logic [7:0] b);
      exp_q.push_back({dc, b});
   endtask

   task automatic push_win(input logic [15:0] xs, input logic [15:0] xe,
                           input logic [15:0] ys, input logic [15:0] ye,
                           input int n, input logic [15:0] col);
      push(1'b0, 8'h2A);
      push(1'b1, xs[15:8]);
      push(1'b1, xs[7:0]);
      push(1'b1, xe[15:8]);
      push(1'b1, xe[7:0]);
      push(1'b0, 8'h2B);
      push(1'b1, ys[15:8]);
      push(1'b1, ys[7:0]);
      push(1'b1, ye[15:8]);
      push(1'b1, ye[7:0]);
      push(1'b0, 8'h2C);
      for (int i = 0; i < n; i++) begin
         push(1'b1, col[15:8]);
         push(1'b1, col[7:0]);
      end
   endtask

   task automatic push_cell(input int cx, input int cy, input logic [15:0] col);
      push_win(16'(cx * CELL), 16'(cx * CELL + CELL - 1),
               16'(cy * CELL), 16'(cy * CELL + CELL - 1),
               CELL * CELL, col);
   endtask

   task automatic wait_obs(input int budget, output bit ok);
      int k;
      k = 0;
      while (obs_q.size() < exp_q.size() && k < budget) begin
         @(negedge hwclk);
         k++;
      end
      ok = (obs_q.size() >= exp_q.size());
   endtask

   task automatic pulse(input int b);
      @(negedge hwclk);
      btn[b] = 1'b1;
      @(negedge hwclk);
      btn[b] = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      nrst = 1'b0;
      btn  = '0;
      repeat (3) begin
         @(negedge hwclk);
         n_cmp++;
         if ({wr, dcx, D} !== {1'b1, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_out: got wr=%b dcx=%b D=%h, need 1 1 00", wr, dcx, D);
         end
      end
      nrst = 1'b1;
      cyc  = 0;
      while (wr !== 1'b0 && cyc < DLY + 20) begin
         @(negedge hwclk);
         cyc++;
      end
      n_cmp++;
      if (cyc < DLY || cyc > DLY + 3) begin
         n_bad++;
         $display("FAIL first_wr_delay: got %0d cycles, need %0d..%0d", cyc, DLY, DLY + 3);
      end
      n_cmp++;
      if ({dcx, D} !== {1'b0, 8'h01}) begin
         n_bad++;
         $display("FAIL first_byte: got dcx=%b D=%h, need 0 01", dcx, D);
      end
   endtask

   task automatic test_init();
      bit ok;
      logic [8:0] e, o;
      push(1'b0, 8'h01);
      push(1'b0, 8'h11);
      push(1'b0, 8'h3A);
      push(1'b1, 8'h55);
      push(1'b0, 8'h36);
      push(1'b1, 8'h00);
      push(1'b0, 8'h29);
      push_win(16'd0, 16'(W - 1), 16'd0, 16'(H - 1), W * H, 16'h0000);
      push_cell(12, 16, 16'hFFFF);
      wait_obs(20000, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL init_len: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
         exp_q.delete();
         obs_q.delete();
      end else begin
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL init_byte %0d: got %h, need %h", i, o, e);
               exp_q.delete();
               obs_q.delete();
            end
         end
      end
      repeat (40) @(negedge hwclk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL init_idle: got %0d extra bytes, need 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_right();
      bit ok;
      logic [8:0] e, o;
      pulse(0);
      push_cell(13, 16, 16'hFFFF);
      wait_obs(400, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL right_len: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
         exp_q.delete();
         obs_q.delete();
      end else begin
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL right_byte %0d: got %h, need %h", i, o, e);
               exp_q.delete();
               obs_q.delete();
            end
         end
      end
      repeat (20) @(negedge hwclk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL right_idle: got %0d extra bytes, need 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_up_left();
      bit ok;
      logic [8:0] e, o;
      @(negedge hwclk);
      btn[3] = 1'b1;
      @(negedge hwclk);
      btn[3] = 1'b0;
      @(negedge hwclk);
      btn[1] = 1'b1;
      @(negedge hwclk);
      btn[1] = 1'b0;
      push_cell(13, 15, 16'hFFFF);
      push_cell(12, 15, 16'hFFFF);
      wait_obs(600, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL upleft_len: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
         exp_q.delete();
         obs_q.delete();
      end else begin
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL upleft_byte %0d: got %h, need %h", i, o, e);
               exp_q.delete();
               obs_q.delete();
            end
         end
      end
   endtask

   task automatic test_mode_down();
      bit ok;
      int y;
      logic [8:0] e, o;
      logic [15:0] col;
      for (int s = 0; s < 32; s++) begin
         if (s == 0) begin
            pulse(4);
            y   = 15;
            col = 16'h0000;
         end else if (s == 1) begin
            pulse(4);
            y   = 15;
            col = 16'hF800;
         end else begin
            pulse(2);
            y   = (15 + s - 1 > 31) ? 31 : 15 + s - 1;
            col = 16'hF800;
         end
         push_cell(12, y, col);
         wait_obs(400, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL step%0d_len: got %0d bytes, need %0d", s, obs_q.size(), exp_q.size());
            exp_q.delete();
            obs_q.delete();
         end else begin
            for (int i = 0; exp_q.size() > 0; i++) begin
               e = exp_q.pop_front();
               o = obs_q.pop_front();
               n_cmp++;
               if (o !== e) begin
                  n_bad++;
                  $display("FAIL step%0d_byte %0d: got %h, need %h", s, i, o, e);
                  exp_q.delete();
                  obs_q.delete();
               end
            end
         end
      end
   endtask

   task automatic test_keyenc();
      bit ok;
      int k;
      logic [8:0] e, o;
      push_cell(13, 31, 16'hF800);
      push_win(16'd0, 16'(W - 1), 16'd0, 16'(H - 1), W * H, 16'h0000);
      push_cell(12, 16, 16'hF800);
      pulse(0);
      k = 0;
      while (obs_q.size() < 3 && k < 100) begin
         @(negedge hwclk);
         k++;
      end
      pulse(5);
      wait_obs(20000, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL keyenc_len: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
         exp_q.delete();
         obs_q.delete();
      end else begin
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL keyenc_byte %0d: got %h, need %h", i, o, e);
               exp_q.delete();
               obs_q.delete();
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k;
      logic [8:0] e, o;
      pulse(5);
      k = 0;
      while ((obs_q.size() < 200 || wr !== 1'b0) && k < 2000) begin
         @(negedge hwclk);
         k++;
      end
      n_cmp++;
      if (wr !== 1'b0) begin
         n_bad++;
         $display("FAIL midclear_strobe: got wr=%b, need 0 before reset", wr);
      end
      #1;
      nrst = 1'b0;
      #1;
      n_cmp++;
      if ({wr, dcx, D} !== {1'b1, 1'b1, 8'h00}) begin
         n_bad++;
         $display("FAIL midclear_reset: got wr=%b dcx=%b D=%h, need 1 1 00", wr, dcx, D);
      end
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge hwclk);
      nrst = 1'b1;
      push(1'b0, 8'h01);
      push(1'b0, 8'h11);
      push(1'b0, 8'h3A);
      push(1'b1, 8'h55);
      push(1'b0, 8'h36);
      push(1'b1, 8'h00);
      push(1'b0, 8'h29);
      push(1'b0, 8'h2A);
      wait_obs(3 * DLY + 200, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL reinit_len: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
         exp_q.delete();
      end else begin
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL reinit_byte %0d: got %h, need %h", i, o, e);
               exp_q.delete();
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_right();
      test_up_left();
      test_mode_down();
      test_keyenc();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
